fetch_unit: RTL

//  Instruction fetch stage. Generates word addresses into the 32x64k instruction memory
//  (synchronous read, Q valid one cycle after A is sampled) and captures the returned words.

---
 rtl/fetch_unit_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared widths and FSM encodings for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned ADDR = 16;
  localparam int unsigned WORD = 32;

  localparam logic [ADDR-1:0] RESET_PC = 16'h0000;

  localparam logic [1:0] FS_IDLE = 2'd0;
  localparam logic [1:0] FS_RUN  = 2'd1;
  localparam logic [1:0] FS_HALT = 2'd2;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry skid buffer (output register + hold entry) between memory response and decode.
// Owns occupancy, flush and the valid/ready handshake toward decode.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [WORD-1:0] push_inst,
  input  logic [ADDR-1:0] push_pc,
  output logic            out_valid,
  output logic [WORD-1:0] out_inst,
  output logic [ADDR-1:0] out_pc,
  input  logic            out_ready,
  output logic            hold_full
);

  logic            hold_valid;
  logic [WORD-1:0] hold_inst;
  logic [ADDR-1:0] hold_pc;
  logic            xfer;

  assign xfer      = out_valid & out_ready;
  assign hold_full = hold_valid;

  // Output register refills from hold first (oldest), then from the incoming response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_pc     <= '0;
      hold_valid <= 1'b0;
      hold_inst  <= '0;
      hold_pc    <= '0;
    end else if (flush) begin
      // A transfer in this cycle still completes at decode; everything left is stale.
      out_valid  <= 1'b0;
      hold_valid <= 1'b0;
    end else if (!out_valid || xfer) begin
      if (hold_valid) begin
        out_valid  <= 1'b1;
        out_inst   <= hold_inst;
        out_pc     <= hold_pc;
        hold_valid <= push;
        if (push) begin
          hold_inst <= push_inst;
          hold_pc   <= push_pc;
        end
      end else if (push) begin
        out_valid <= 1'b1;
        out_inst  <= push_inst;
        out_pc    <= push_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (push) begin
      hold_valid <= 1'b1;
      hold_inst  <= push_inst;
      hold_pc    <= push_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: pc/FSM/in-flight tracking and redirect, feeding a skid buffer.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            halt_req,
  input  logic            redirect_valid,
  input  logic [ADDR-1:0] redirect_pc,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_write,
  output logic [WORD-1:0] mem_din,
  input  logic [WORD-1:0] mem_dout,
  output logic            inst_valid,
  output logic [WORD-1:0] inst,
  output logic [ADDR-1:0] inst_pc,
  input  logic            inst_ready,
`ifdef FETCH_PERF_EN
  output logic [31:0]     fetch_count,
  output logic [31:0]     stall_count,
`endif
  output logic            running
);

  logic [1:0]      state;
  logic [ADDR-1:0] pc;
  logic            inflight;
  logic [ADDR-1:0] inflight_pc;
  logic            hold_full;
  logic            xfer;
  logic            slot_ok;
  logic            issue;
  logic            resp_valid;

  assign mem_addr  = pc;
  assign mem_write = 1'b0;
  assign mem_din   = '0;
  assign running   = (state == FS_RUN);
  assign xfer      = inst_valid & inst_ready;

  // Issue only when the response is guaranteed a free buffer slot on arrival.
  always_comb begin
    slot_ok = 1'b0;
    if (hold_full) begin
      slot_ok = !inflight && xfer;
    end else begin
      slot_ok = !(inflight && inst_valid && !inst_ready);
    end
  end

  assign issue      = running && !halt_req && !redirect_valid && slot_ok;
  // A response landing in a redirect cycle belongs to the old path.
  assign resp_valid = inflight && !redirect_valid;

  // Run-state FSM; redirect only blocks the RUN->HALT move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FS_IDLE;
    end else begin
      case (state)
        FS_IDLE: if (start) state <= FS_RUN;
        FS_RUN:  if (halt_req && !redirect_valid) state <= FS_HALT;
        FS_HALT: if (start && !halt_req) state <= FS_RUN;
        default: state <= FS_IDLE;
      endcase
    end
  end

  // Program counter and in-flight read tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc          <= pc + 16'd1;
        inflight_pc <= pc;
      end
    end
  end

  fetch_buffer u_buffer (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (resp_valid),
    .push_inst (mem_dout),
    .push_pc   (inflight_pc),
    .out_valid (inst_valid),
    .out_inst  (inst),
    .out_pc    (inst_pc),
    .out_ready (inst_ready),
    .hold_full (hold_full)
  );

`ifdef FETCH_PERF_EN
  // Saturating issue and backpressure counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (issue && fetch_count != 32'hFFFF_FFFF) fetch_count <= fetch_count + 32'd1;
      if (running && inst_valid && !inst_ready && stall_count != 32'hFFFF_FFFF) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule
